// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings plus the request alignment rule and the small
// record types used by single-transfer initiators.
package ahblite_pkg;

  localparam int HADDR_W = 32;
  localparam int HDATA_W = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Data-phase bookkeeping for the transfer currently owning the data bus.
  typedef struct packed {
    logic               active;
    logic               write;
    logic [HDATA_W-1:0] wdata;
  } dphase_t;

  typedef struct packed {
    logic               valid;
    logic               err;
    logic [HDATA_W-1:0] rdata;
  } rsp_t;

  // Sizes above a word are not supported by a 32-bit bus and count as misaligned.
  function automatic logic size_addr_misaligned(input logic [2:0] size,
                                                input logic [1:0] addr_lo);
    logic bad;
    case (size)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = addr_lo[0];
      HSIZE_WORD: bad = (addr_lo != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahblite_simple_master.sv
// AHB-Lite single-transfer initiator: valid/ready requests become NONSEQ SINGLE
// transfers with overlapped address/data phases and one in-order response each.
module ahblite_simple_master
  import ahblite_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL   = 4'b0011,
  parameter bit         ALIGN_CHECK = 1'b1
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [HADDR_W-1:0]  req_addr,
  input  logic [2:0]          req_size,
  input  logic [HDATA_W-1:0]  req_wdata,
  output logic                rsp_valid,
  output logic [HDATA_W-1:0]  rsp_rdata,
  output logic                rsp_err,
  output logic [HADDR_W-1:0]  HADDR,
  output logic [1:0]          HTRANS,
  output logic [2:0]          HSIZE,
  output logic [2:0]          HBURST,
  output logic [3:0]          HPROT,
  output logic                HMASTLOCK,
  output logic                HWRITE,
  output logic [HDATA_W-1:0]  HWDATA,
  input  logic                HREADY,
  input  logic [HDATA_W-1:0]  HRDATA,
  input  logic                HRESP
);

  dphase_t dp_q, dp_d;
  rsp_t    rsp_q, rsp_d;
  logic    lerr_q, lerr_d;

  logic req_misaligned;
  logic bus_eligible;
  logic dp_done;
  logic bus_accept;
  logic lerr_accept;

  always_comb begin
    req_misaligned = ALIGN_CHECK && size_addr_misaligned(req_size, req_addr[1:0]);
    bus_eligible   = req_valid && !req_misaligned;
    dp_done        = dp_q.active && HREADY;
    // No new address phase is offered during either cycle of an ERROR response.
    bus_accept     = bus_eligible && HREADY && (HRESP == HRESP_OKAY);
    // A local error only takes a slot once the bus response ahead of it is
    // being produced, which keeps responses in request order.
    lerr_accept    = req_valid && req_misaligned && (!dp_q.active || HREADY);
  end

  // Address phase: driven straight from the request; reset forces the idle bus.
  always_comb begin
    HTRANS    = HTRANS_IDLE;
    HADDR     = '0;
    HSIZE     = '0;
    HWRITE    = 1'b0;
    req_ready = 1'b0;
    if (!HRESET) begin
      HADDR     = req_addr;
      HSIZE     = req_size;
      HWRITE    = req_write;
      req_ready = bus_accept || lerr_accept;
      if (bus_eligible && (HRESP == HRESP_OKAY)) begin
        HTRANS = HTRANS_NONSEQ;
      end
    end
  end

  // Data phase and response: next-state for the registered side.
  always_comb begin
    dp_d   = dp_q;
    lerr_d = lerr_accept;
    rsp_d  = '0;

    if (dp_done) begin
      dp_d.active = 1'b0;
    end
    if (bus_accept) begin
      dp_d.active = 1'b1;
      dp_d.write  = req_write;
      dp_d.wdata  = req_wdata;
    end

    // A pending local error never coincides with a completing bus transfer:
    // the cycle it was accepted in could not also accept a bus request.
    if (dp_done) begin
      rsp_d.valid = 1'b1;
      rsp_d.err   = (HRESP == HRESP_ERROR);
      rsp_d.rdata = (!dp_q.write && (HRESP == HRESP_OKAY)) ? HRDATA : '0;
    end else if (lerr_q) begin
      rsp_d.valid = 1'b1;
      rsp_d.err   = 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_q   <= '0;
      rsp_q  <= '0;
      lerr_q <= 1'b0;
    end else begin
      dp_q   <= dp_d;
      rsp_q  <= rsp_d;
      lerr_q <= lerr_d;
    end
  end

  assign HWDATA    = dp_q.wdata;
  assign rsp_valid = rsp_q.valid;
  assign rsp_err   = rsp_q.err;
  assign rsp_rdata = rsp_q.rdata;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

endmodule
